// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define FIFO_REG_OUT_EN for a registered pop_data; default is show-ahead.
module fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0]   AE_C    = (AW+1)'(AE_THRESH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_acc;
    logic          pop_acc;

    // A full FIFO still takes a push when the same cycle frees a slot.
    assign pop_acc  = pop & ~empty_q;
    assign push_acc = push & (~full_q | pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_acc) wptr_d = wptr_q + PTR_ONE;
        if (pop_acc)  rptr_d = rptr_q + PTR_ONE;
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = push & full_q & ~pop;
        unf_d   = pop & empty_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage carries no reset; a reset cycle must not write it.
    always_ff @(posedge clk) begin
        if (rst && push_acc) mem_q[wptr_q] <= push_data;
    end

`ifdef FIFO_REG_OUT_EN
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (pop_acc) rdata_d = mem_q[rptr_q];
    end

    always_ff @(posedge clk) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign pop_data = rdata_q;
`else
    assign pop_data = mem_q[rptr_q];
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (default parameters).
// Data checks follow the pop timing of the selected output mode.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0;
    logic [7:0] push_data = '0;
    logic       pop = 1'b0;
    logic [7:0] pop_data;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .pop_data     (pop_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, optionally check the popped word.
    task automatic step(input logic psh, input logic [7:0] d,
                        input logic pp, input logic dchk,
                        input logic [7:0] exp, input string tag);
        push      = psh;
        push_data = d;
        pop       = pp;
`ifndef FIFO_REG_OUT_EN
        #1;
        if (dchk) chk(tag, int'(pop_data), int'(exp));
`endif
        @(posedge clk);
        #1;
`ifdef FIFO_REG_OUT_EN
        if (dchk) chk(tag, int'(pop_data), int'(exp));
`endif
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_ae"}, int'(almost_empty), 1);
        chk({tag, "_af"}, int'(almost_full), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
        chk({tag, "_unf"}, int'(underflow), 0);
    endtask

    initial begin
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_reset_state("rst");
`ifdef FIFO_REG_OUT_EN
        chk("rst_pdata", int'(pop_data), 0);
`endif

        // basic ordering
        step(1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, "");
        chk("b_cnt1", int'(count), 1);
        step(1'b1, 8'hB2, 1'b0, 1'b0, 8'h00, "");
        chk("b_cnt2", int'(count), 2);
        step(1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, "");
        chk("b_cnt3", int'(count), 3);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, "b_pop1");
        chk("b_cnt4", int'(count), 2);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, "b_pop2");
        chk("b_cnt5", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, "b_pop3");
        chk("b_cnt6", int'(count), 0);
        chk("b_empty", int'(empty), 1);
        chk("b_unf", int'(underflow), 0);
        chk("b_ovf", int'(overflow), 0);

        // fill to full
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i[7:0], 1'b0, 1'b0, 8'h00, "");
            chk("f_cnt", int'(count), i + 1);
            chk("f_ae", int'(almost_empty), int'(i + 1 <= 2));
            chk("f_af", int'(almost_full), int'(i + 1 >= 14));
            chk("f_full", int'(full), int'(i + 1 == 16));
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, "");
        chk("o_ovf", int'(overflow), 1);
        chk("o_cnt", int'(count), 16);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "");
        chk("o_ovf_clr", int'(overflow), 0);

        // full with push and pop together
        step(1'b1, 8'h55, 1'b1, 1'b1, 8'h00, "fp_pop");
        chk("fp_cnt", int'(count), 16);
        chk("fp_full", int'(full), 1);
        chk("fp_ovf", int'(overflow), 0);
        for (int i = 1; i < 16; i++)
            step(1'b0, 8'h00, 1'b1, 1'b1, i[7:0], "fp_drain");
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h55, "fp_last");
        chk("fp_empty", int'(empty), 1);

        // empty with push and pop together
        step(1'b1, 8'h77, 1'b1, 1'b0, 8'h00, "");
        chk("ep_unf", int'(underflow), 1);
        chk("ep_cnt", int'(count), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, "");
        chk("ep_unf_clr", int'(underflow), 0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h77, "ep_pop");
        chk("ep_cnt2", int'(count), 0);

        // wrap-around streaming
        for (int i = 0; i < 5; i++)
            step(1'b1, i[7:0], 1'b0, 1'b0, 8'h00, "");
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(i + 5), 1'b1, 1'b1, i[7:0], "w_data");
            chk("w_cnt", int'(count), 5);
        end
        for (int i = 40; i < 45; i++)
            step(1'b0, 8'h00, 1'b1, 1'b1, i[7:0], "w_drain");
        chk("w_empty", int'(empty), 1);

        // reset mid-operation
        for (int i = 0; i < 9; i++)
            step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 8'h00, "");
        chk("r_cnt9", int'(count), 9);
        rst = 1'b0;
        step(1'b1, 8'h99, 1'b1, 1'b0, 8'h00, "");
        rst = 1'b1;
        chk_reset_state("r");
`ifdef FIFO_REG_OUT_EN
        chk("r_pdata", int'(pop_data), 0);
`endif
        step(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00, "");
        chk("r_cnt1", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, "r_pop");
        chk("r_empty", int'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
